// File: rtl/state_pack_cit__pack_poly__ctrl.sv
// 3-bit coefficient packer for one compressed polynomial.
// Gathers eight 3-bit coefficients, then emits three bytes LSB-first.
// This repeats for KYBER_N/8 groups, then pulses o_done.
//
// state  | meaning
// IDLE   | waiting for i_start, all handshakes low
// GATHER | accepting coefficients into slots c0..c7
// EMIT   | presenting packed bytes b0..b2 to the byte buffer
// DONE   | one-cycle end-of-polynomial pulse
module state_pack_cit__pack_poly__ctrl #(
    parameter  int KYBER_N            = 256,
    parameter  int i_Width            = 8,
    parameter  int o_Ciphertext_Width = 8,
    localparam int NBYTES             = KYBER_N * 3 / 8,
    localparam int IDX_W              = $clog2(NBYTES)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [i_Width-1:0]            i_coeff,
    input  logic                          i_coeff_valid,
    output logic                          o_coeff_ready,
    output logic [o_Ciphertext_Width-1:0] o_byte,
    output logic                          o_byte_valid,
    input  logic                          i_byte_ready,
    output logic [IDX_W-1:0]              o_byte_idx,
    output logic                          o_busy,
    output logic                          o_done
);

    localparam int                NGRP     = KYBER_N / 8;
    localparam int                GRP_W    = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam logic [GRP_W-1:0]  GRP_LAST = GRP_W'(NGRP - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GATHER = 2'd1,
        S_EMIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                          r_state;
    logic [7:0][2:0]                 r_c;
    logic [2:0]                      r_coeff_cnt;
    logic [1:0]                      r_emit_cnt;
    logic [GRP_W-1:0]                r_grp_cnt;
    logic [IDX_W-1:0]                r_byte_idx;
    logic [o_Ciphertext_Width-1:0]   r_byte;
    logic                            r_coeff_ready;
    logic                            r_byte_valid;
    logic                            r_busy;
    logic                            r_done;

    logic [7:0] w_b0;
    logic [7:0] w_b1;
    logic [7:0] w_b2;

    // Only the low three coefficient bits carry data; the rest are dropped on purpose.
    logic w_unused_coeff_hi;
    assign w_unused_coeff_hi = ^i_coeff[i_Width-1:3];

    // Packed byte candidates; bits shifted past bit 7 fall off the 8-bit result.
    always_comb begin
        w_b0 = {5'b0, r_c[0]} | ({5'b0, r_c[1]} << 3) | ({5'b0, r_c[2]} << 6);
        w_b1 = ({5'b0, r_c[2]} >> 2) | ({5'b0, r_c[3]} << 1) |
               ({5'b0, r_c[4]} << 4) | ({5'b0, r_c[5]} << 7);
        w_b2 = ({5'b0, r_c[5]} >> 1) | ({5'b0, r_c[6]} << 2) | ({5'b0, r_c[7]} << 5);
    end

    // Sequencer with registered handshakes, byte, index and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_c           <= '0;
            r_coeff_cnt   <= '0;
            r_emit_cnt    <= '0;
            r_grp_cnt     <= '0;
            r_byte_idx    <= '0;
            r_byte        <= '0;
            r_coeff_ready <= 1'b0;
            r_byte_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state       <= S_GATHER;
                        r_coeff_ready <= 1'b1;
                        r_busy        <= 1'b1;
                        r_coeff_cnt   <= '0;
                        r_grp_cnt     <= '0;
                        r_byte_idx    <= '0;
                    end
                end
                S_GATHER: begin
                    if (i_coeff_valid && r_coeff_ready) begin
                        r_c[r_coeff_cnt] <= i_coeff[2:0];
                        r_coeff_cnt      <= r_coeff_cnt + 3'd1;
                        if (r_coeff_cnt == 3'd7) begin
                            // c0..c2 are already held, so b0 can be loaded now.
                            r_state       <= S_EMIT;
                            r_coeff_ready <= 1'b0;
                            r_byte_valid  <= 1'b1;
                            r_byte        <= w_b0;
                            r_emit_cnt    <= '0;
                        end
                    end
                end
                S_EMIT: begin
                    if (r_byte_valid && i_byte_ready) begin
                        r_emit_cnt <= r_emit_cnt + 2'd1;
                        case (r_emit_cnt)
                            2'd0: begin
                                r_byte     <= w_b1;
                                r_byte_idx <= r_byte_idx + 1'b1;
                            end
                            2'd1: begin
                                r_byte     <= w_b2;
                                r_byte_idx <= r_byte_idx + 1'b1;
                            end
                            default: begin
                                r_byte_valid <= 1'b0;
                                r_byte       <= '0;
                                if (r_grp_cnt == GRP_LAST) begin
                                    // Index parks at 0 rather than stepping past the last byte.
                                    r_state    <= S_DONE;
                                    r_done     <= 1'b1;
                                    r_byte_idx <= '0;
                                end else begin
                                    r_state       <= S_GATHER;
                                    r_grp_cnt     <= r_grp_cnt + 1'b1;
                                    r_coeff_ready <= 1'b1;
                                    r_coeff_cnt   <= '0;
                                    r_byte_idx    <= r_byte_idx + 1'b1;
                                end
                            end
                        endcase
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_coeff_ready = r_coeff_ready;
    assign o_byte        = r_byte;
    assign o_byte_valid  = r_byte_valid;
    assign o_byte_idx    = r_byte_idx;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

endmodule

// File: tb/tb_state_pack_cit__pack_poly__ctrl.sv
// Scoreboard bench for the 3-bit polynomial packer.
module tb_state_pack_cit__pack_poly__ctrl;

    localparam int KN = 256;
    localparam int NB = 96;
    localparam int IW = 7;
    localparam int T  = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [7:0]    i_coeff = '0;
    logic          i_coeff_valid = 1'b0;
    logic          i_byte_ready = 1'b1;
    logic          o_coeff_ready;
    logic [7:0]    o_byte;
    logic          o_byte_valid;
    logic [IW-1:0] o_byte_idx;
    logic          o_busy;
    logic          o_done;

    typedef struct packed {
        logic [7:0]    b;
        logic [IW-1:0] idx;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   bytes_seen = 0;
    int   done_cnt = 0;
    bit   rdy_rand = 1'b0;
    bit   abort = 1'b0;

    state_pack_cit__pack_poly__ctrl #(
        .KYBER_N(KN), .i_Width(8), .o_Ciphertext_Width(8)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_coeff(i_coeff),
        .i_coeff_valid(i_coeff_valid), .o_coeff_ready(o_coeff_ready),
        .o_byte(o_byte), .o_byte_valid(o_byte_valid), .i_byte_ready(i_byte_ready),
        .o_byte_idx(o_byte_idx), .o_busy(o_busy), .o_done(o_done)
    );

    always #(T/2) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] coeff_of(input int pat, input int i);
        case (pat)
            0:       return 8'h00;
            1:       return 8'(i % 8);
            default: return 8'hFF;
        endcase
    endfunction

    task automatic push_run(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        for (int g = 0; g < NB / 3; g++) begin
            sb.push_back('{b: b0, idx: IW'(3*g)});
            sb.push_back('{b: b1, idx: IW'(3*g + 1)});
            sb.push_back('{b: b2, idx: IW'(3*g + 2)});
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_coeff_ready"}, 32'(o_coeff_ready), 0);
        check({tag, "_byte"},        32'(o_byte), 0);
        check({tag, "_byte_valid"},  32'(o_byte_valid), 0);
        check({tag, "_byte_idx"},    32'(o_byte_idx), 0);
        check({tag, "_busy"},        32'(o_busy), 0);
        check({tag, "_done"},        32'(o_done), 0);
    endtask

    task automatic monitor_loop();
        logic          held_v = 1'b0;
        logic [7:0]    hb = '0;
        logic [IW-1:0] hi = '0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
            end else begin
                check("coeff_ready_during_emit", 32'(o_coeff_ready & o_byte_valid), 0);
                if (held_v) begin
                    check("stall_valid", 32'(o_byte_valid), 1);
                    check("stall_byte",  32'(o_byte), 32'(hb));
                    check("stall_idx",   32'(o_byte_idx), 32'(hi));
                end
                held_v = o_byte_valid && !i_byte_ready;
                hb = o_byte;
                hi = o_byte_idx;
                if (o_byte_valid && i_byte_ready) begin
                    bytes_seen++;
                    check("sb_has_entry", 32'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("byte",     32'(o_byte), 32'(e.b));
                        check("byte_idx", 32'(o_byte_idx), 32'(e.idx));
                    end
                end
                if (o_done) done_cnt++;
            end
        end
    endtask

    task automatic ready_loop();
        forever begin
            @(posedge clk);
            #1;
            i_byte_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic feed(input int pat, input bit gap, input bit inject);
        bit hs;
        int guard;
        for (int i = 0; i < KN && !abort; i++) begin
            if (gap && $urandom_range(0, 2) == 0) begin
                i_coeff_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            i_coeff = coeff_of(pat, i);
            i_coeff_valid = 1'b1;
            if (inject && i == 100) i_start = 1'b1;
            hs = 1'b0;
            guard = 0;
            while (!hs && !abort) begin
                @(negedge clk);
                hs = o_coeff_ready;
                @(posedge clk);
                #1;
                i_start = 1'b0;
                guard++;
                if (guard > 200) begin
                    check("coeff_accept_timeout", 32'(hs), 1);
                    abort = 1'b1;
                end
            end
        end
        i_coeff_valid = 1'b0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic run(input int pat, input bit gap, input bit rr, input bit inject,
                       input bit chk_lat, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2);
        int     d0;
        int     g;
        longint t0;
        longint t1;
        push_run(b0, b1, b2);
        rdy_rand = rr;
        abort = 1'b0;
        d0 = done_cnt;
        pulse_start();
        t0 = $time;
        feed(pat, gap, inject);
        g = 0;
        while (g < 5000) begin
            @(negedge clk);
            g++;
            if (o_done) break;
        end
        t1 = $time;
        check("done_seen", 32'(o_done), 1);
        if (chk_lat) check("done_latency", 32'((t1 - t0) / T), 352);
        if (inject) i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        @(negedge clk);
        check("busy_after_done", 32'(o_busy), 0);
        check("done_one_cycle",  32'(o_done), 0);
        check("done_count",      32'(done_cnt - d0), 1);
        check("sb_drained",      32'(sb.size()), 0);
        sb.delete();
        rdy_rand = 1'b0;
    endtask

    task automatic main_flow();
        int base;
        int g;
        // Reset with i_start held: reset must win.
        rst = 1'b1;
        i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        i_start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        run(0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        run(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h88, 8'hC6, 8'hFA);
        run(2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
        run(1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h88, 8'hC6, 8'hFA);

        // Mid-polynomial reset after 40 bytes.
        push_run(8'h88, 8'hC6, 8'hFA);
        abort = 1'b0;
        base = bytes_seen;
        pulse_start();
        fork
            feed(1, 1'b0, 1'b0);
            begin
                g = 0;
                while (bytes_seen < base + 40 && g < 5000) begin
                    @(negedge clk);
                    g++;
                end
                check("reached_40_bytes", 32'(bytes_seen >= base + 40), 1);
                abort = 1'b1;
            end
        join
        i_coeff_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("midrun_reset");
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        abort = 1'b0;
        run(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h88, 8'hC6, 8'hFA);

        // Extra start pulses mid-run and in DONE.
        run(1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h88, 8'hC6, 8'hFA);
        repeat (3) @(negedge clk);
        check("idle_after_ignored_start", 32'(o_busy), 0);
    endtask

    initial begin
        fork
            monitor_loop();
            ready_loop();
            main_flow();
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/state_pack_cit__pack_poly__ctrl.md
Name: state_pack_cit__pack_poly__ctrl

Overview:
- Sequences 3-bit packing of one compressed polynomial into the ciphertext byte stream.
- Accepts KYBER_N coefficients one per beat, gathers groups of 8, and emits 3 packed bytes per group, LSB-first.
- Sits between the compress stage and the ciphertext byte buffer.
- Runs one polynomial per start pulse and raises done when all KYBER_N*3/8 bytes have been handed off.

Parameters:
- KYBER_N, 256, coefficients per polynomial; must be a multiple of 8.
- i_Width, 8, coefficient input width; only bits [2:0] are used.
- o_Ciphertext_Width, 8, output byte width; fixed at 8.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_start  input  1  one-cycle pulse starting one polynomial; honoured only in IDLE.
- i_coeff  input  i_Width  coefficient; bits [2:0] used, upper bits ignored.
- i_coeff_valid  input  1  i_coeff is valid.
- o_coeff_ready  output  1  block accepts i_coeff this cycle.
- o_byte  output  o_Ciphertext_Width  packed ciphertext byte.
- o_byte_valid  output  1  o_byte is valid.
- i_byte_ready  input  1  downstream accepts o_byte.
- o_byte_idx  output  clog2(KYBER_N*3/8)  offset of o_byte within the polynomial, 0..95 by default.
- o_busy  output  1  high in every state except IDLE.
- o_done  output  1  one-cycle pulse at end of polynomial.

Behaviour:
- Reset: on rst=1 at a clock edge, state=IDLE and all outputs drive 0 (o_coeff_ready, o_byte, o_byte_valid, o_byte_idx, o_busy, o_done). Group register and counters clear. rst overrides every other input, including mid-polynomial; the partial polynomial is discarded and no done pulse is issued.
- Handshakes: a coefficient transfers when i_coeff_valid && o_coeff_ready. A byte transfers when o_byte_valid && i_byte_ready. Once o_byte_valid rises, o_byte and o_byte_idx hold stable until the transfer.
- IDLE: o_coeff_ready=0, o_byte_valid=0. i_start=1 moves to GATHER and clears grp_cnt, coeff_cnt and byte_idx.
- GATHER:
  - o_coeff_ready=1.
  - Each transfer stores i_coeff[2:0] into slot c[coeff_cnt], where coeff_cnt runs 0..7.
  - On the transfer that fills c7, move to EMIT with emit_cnt=0.
  - No bubbles: one coefficient per cycle while valid is held high.
- EMIT:
  - o_coeff_ready=0, o_byte_valid=1.
  - Byte selected by emit_cnt:
    - emit_cnt 0: b0 = c0 | c1<<3 | c2<<6
    - emit_cnt 1: b1 = c2>>2 | c3<<1 | c4<<4 | c5<<7
    - emit_cnt 2: b2 = c5>>1 | c6<<2 | c7<<5
  - Each expression is computed at 8-bit width; bits shifted above bit 7 are dropped.
  - Each byte transfer increments emit_cnt and byte_idx.
  - On the b2 transfer: if grp_cnt = KYBER_N/8-1, move to DONE; otherwise increment grp_cnt and return to GATHER.
- DONE: o_done=1 for exactly one cycle, o_busy=1, then return to IDLE. o_byte_idx returns to 0 in IDLE.
- Latency:
  - First byte is valid the cycle after the 8th coefficient is accepted.
  - Under no backpressure, one group takes 11 cycles (8 gather + 3 emit) and a 256-coefficient polynomial takes 352 cycles plus the DONE cycle.
- Boundaries:
  - i_start outside IDLE is ignored.
  - i_coeff_valid outside GATHER is ignored; nothing is stored.
  - i_byte_ready low stalls EMIT indefinitely with no data loss.
  - i_start and rst asserted together: rst wins.
  - i_start in the DONE cycle is ignored.
  - byte_idx never wraps within a polynomial.

Test Plan:
- Reset, start, feed 256 zeros with i_byte_ready=1 -> 96 bytes of 0x00, o_byte_idx 0..95, o_done pulses once on the cycle after byte 95, total 353 cycles from the start edge.
- Feed coefficients repeating 0,1,2,3,4,5,6,7 -> every group yields 0x88, 0xC6, 0xFA.
- Feed all 0x07 with upper bits set to 0xFF -> 96 bytes of 0xFF; the upper bits have no effect.
- Same pattern as the second scenario with i_byte_ready toggled pseudo-randomly and i_coeff_valid gapped -> identical byte sequence and indices; o_byte stays stable while stalled; no coefficient accepted during EMIT.
- Assert rst after 40 bytes -> next cycle all outputs are 0 and state is IDLE; a new start then produces a full correct 96-byte run with idx starting at 0.
- Pulse i_start again mid-run and during DONE -> ignored; exactly 96 bytes and one o_done per accepted start.
